// File: rtl/dtb_pkg.sv
// Shared sizing, control/status types and capture FSM states for the Data Trace Buffer.
package dtb_pkg;

  localparam int TRB_WIDTH       = 32;
  localparam int TRB_DEPTH       = 32;
  localparam int TRB_MAX_TRACES  = 8;
  localparam int TRB_DELAY_BITS  = 2;
  localparam int TRB_NTRACE_BITS = 2;

  localparam int TRB_WADDR_BITS  = $clog2(TRB_DEPTH);
  localparam int TRB_POST_UNIT   = TRB_DEPTH / 4;
  localparam int TRB_POS_BITS    = $clog2(TRB_WIDTH);

  typedef struct packed {
    logic                       trg_mode;
    logic [TRB_DELAY_BITS-1:0]  trg_delay;
    logic [TRB_NTRACE_BITS-1:0] trg_num_traces;
  } control_t;

  typedef struct packed {
    logic                      trg_event;
    logic [TRB_POS_BITS-1:0]   event_pos;
    logic [TRB_WADDR_BITS-1:0] event_addr;
  } status_t;

  localparam control_t CONTROL_DEFAULT = '0;
  localparam status_t  STATUS_DEFAULT  = '0;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    POST,
    DONE
  } capture_state_t;

  // Bits per sample for a given trace-count selector (1, 2, 4 or 8).
  function automatic logic [TRB_POS_BITS:0] sample_bits(input logic [TRB_NTRACE_BITS-1:0] nsel);
    return (TRB_POS_BITS+1)'(1) << nsel;
  endfunction

endpackage

// File: rtl/dtb_sample_packer.sv
// Packs 1/2/4/8-bit samples LSB-first into TRB_WIDTH-bit words; flags the sample that completes a word.
module dtb_sample_packer
  import dtb_pkg::*;
(
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [TRB_NTRACE_BITS-1:0] nsel_i,
  input  logic [TRB_MAX_TRACES-1:0]  sample_i,
  input  logic                       valid_i,
  input  logic                       clear_i,
  output logic [TRB_WIDTH-1:0]       word_o,
  output logic                       word_valid_o,
  output logic [TRB_POS_BITS-1:0]    offset_o
);

  logic [TRB_WIDTH-1:0]      r_acc;
  logic [TRB_POS_BITS-1:0]   r_offset;
  logic [TRB_POS_BITS:0]     w_n;
  logic [TRB_MAX_TRACES-1:0] w_mask;
  logic [TRB_WIDTH-1:0]      w_merged;
  logic                      w_end;

  always_comb begin
    w_mask = '0;
    case (nsel_i)
      2'd0:    w_mask = 8'h01;
      2'd1:    w_mask = 8'h03;
      2'd2:    w_mask = 8'h0F;
      default: w_mask = 8'hFF;
    endcase
  end

  assign w_n      = sample_bits(nsel_i);
  assign w_merged = r_acc | (TRB_WIDTH'(sample_i & w_mask) << r_offset);
  assign w_end    = (({1'b0, r_offset} + w_n) == (TRB_POS_BITS+1)'(TRB_WIDTH));

  // The completing sample is presented merged so the caller can register the full word this cycle.
  assign word_o       = w_merged;
  assign word_valid_o = valid_i & ~clear_i & w_end;
  assign offset_o     = r_offset;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_acc    <= '0;
      r_offset <= '0;
    end else if (clear_i) begin
      r_acc    <= '0;
      r_offset <= '0;
    end else if (valid_i) begin
      if (w_end) begin
        r_acc    <= '0;
        r_offset <= '0;
      end else begin
        r_acc    <= w_merged;
        r_offset <= r_offset + w_n[TRB_POS_BITS-1:0];
      end
    end
  end

endmodule

// File: rtl/dtb_trace_capture.sv
// Trace capture front-end: trigger FSM, post-trigger window, circular BRAM write port and status.
//   state | meaning
//   IDLE  | no capture
//   ARMED | capturing, waiting for trigger
//   POST  | trigger seen, counting post-trigger words
//   DONE  | window complete (streaming continues if trg_mode=1)
module dtb_trace_capture
  import dtb_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      arm_i,
  input  control_t                  control_i,
  input  logic [TRB_MAX_TRACES-1:0] trace_i,
  input  logic                      trace_valid_i,
  input  logic                      trigger_i,
  output status_t                   status_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      we_o,
  output logic [TRB_WADDR_BITS-1:0] waddr_o,
  output logic [TRB_WIDTH-1:0]      wdata_o
);

  capture_state_t            r_state;
  capture_state_t            w_state_nxt;
  control_t                  r_ctrl;
  status_t                   r_status;
  logic                      r_we;
  logic [TRB_WADDR_BITS-1:0] r_waddr;
  logic [TRB_WADDR_BITS-1:0] r_wptr;
  logic [TRB_WIDTH-1:0]      r_wdata;
  logic [TRB_WADDR_BITS-1:0] r_post_cnt;

  logic                      w_accept;
  logic                      w_trigger;
  logic                      w_word_valid;
  logic [TRB_WIDTH-1:0]      w_word;
  logic [TRB_POS_BITS-1:0]   w_offset;
  logic [TRB_WADDR_BITS-1:0] w_post_words;
  logic                      w_last_write;

  assign w_accept = trace_valid_i & ~arm_i &
                    ((r_state == ARMED) | (r_state == POST) | ((r_state == DONE) & r_ctrl.trg_mode));
  assign w_trigger = (r_state == ARMED) & trace_valid_i & trigger_i & ~arm_i;

  assign w_post_words = TRB_WADDR_BITS'(r_ctrl.trg_delay * TRB_POST_UNIT);
  // Every write seen in POST is the trigger word or a later one; the trigger word is write 0.
  assign w_last_write = (r_state == POST) & r_we & (r_post_cnt == w_post_words);

  dtb_sample_packer u_packer (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .nsel_i       (r_ctrl.trg_num_traces),
    .sample_i     (trace_i),
    .valid_i      (w_accept),
    .clear_i      (arm_i),
    .word_o       (w_word),
    .word_valid_o (w_word_valid),
    .offset_o     (w_offset)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (arm_i) begin
      w_state_nxt = ARMED;
    end else begin
      case (r_state)
        ARMED:   if (w_trigger) w_state_nxt = POST;
        POST:    if (w_last_write) w_state_nxt = DONE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ctrl     <= CONTROL_DEFAULT;
      r_status   <= STATUS_DEFAULT;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wptr     <= '0;
      r_wdata    <= '0;
      r_post_cnt <= '0;
    end else begin
      r_we <= w_word_valid;
      if (w_word_valid) begin
        r_wdata <= w_word;
        r_waddr <= r_wptr;
      end
      if (arm_i) begin
        r_ctrl     <= control_i;
        r_status   <= STATUS_DEFAULT;
        r_wptr     <= '0;
        r_post_cnt <= '0;
      end else begin
        if (w_word_valid) r_wptr <= r_wptr + 1'b1;
        // The word being packed lands at r_wptr, even when the trigger sample completes it.
        if (w_trigger) r_status <= '{trg_event: 1'b1, event_pos: w_offset, event_addr: r_wptr};
        if ((r_state == POST) && r_we) r_post_cnt <= r_post_cnt + 1'b1;
      end
    end
  end

  assign status_o = r_status;
  assign busy_o   = (r_state == ARMED) | (r_state == POST);
  assign done_o   = (r_state == DONE);
  assign we_o     = r_we;
  assign waddr_o  = r_waddr;
  assign wdata_o  = r_wdata;

endmodule

// File: tb/tb_dtb_trace_capture.sv
// Scoreboard bench for dtb_trace_capture: stimulus queues expected BRAM writes, a monitor checks them.
module tb_dtb_trace_capture;
  import dtb_pkg::*;

  typedef struct packed {
    logic [TRB_WADDR_BITS-1:0] addr;
    logic [TRB_WIDTH-1:0]      data;
  } wr_t;

  logic                      clk;
  logic                      rst_n;
  logic                      arm;
  control_t                  control;
  logic [TRB_MAX_TRACES-1:0] trace;
  logic                      trace_valid;
  logic                      trigger;
  status_t                   status;
  logic                      busy;
  logic                      done;
  logic                      we;
  logic [TRB_WADDR_BITS-1:0] waddr;
  logic [TRB_WIDTH-1:0]      wdata;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  dtb_trace_capture dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .arm_i         (arm),
    .control_i     (control),
    .trace_i       (trace),
    .trace_valid_i (trace_valid),
    .trigger_i     (trigger),
    .status_o      (status),
    .busy_o        (busy),
    .done_o        (done),
    .we_o          (we),
    .waddr_o       (waddr),
    .wdata_o       (wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: every write the DUT presents must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && we) begin
      wr_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_write got addr=%0d data=%08h, none expected", waddr, wdata);
      end else begin
        e = exp_q.pop_front();
        if (waddr !== e.addr || wdata !== e.data) begin
          n_errors++;
          $display("FAIL bram_write got addr=%0d data=%08h expected addr=%0d data=%08h",
                   waddr, wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_status(input string name, input logic ev, input int pos, input int addr);
    chk({name, ".trg_event"}, 32'(status.trg_event), 32'(ev));
    chk({name, ".event_pos"}, 32'(status.event_pos), 32'(pos));
    chk({name, ".event_addr"}, 32'(status.event_addr), 32'(addr));
  endtask

  function automatic control_t mk_ctrl(input logic mode, input int delay, input int nt);
    control_t c;
    c.trg_mode       = mode;
    c.trg_delay      = TRB_DELAY_BITS'(delay);
    c.trg_num_traces = TRB_NTRACE_BITS'(nt);
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // A valid triggering sample rides along with every arm and must be dropped.
  task automatic do_arm(input control_t c);
    control     = c;
    arm         = 1'b1;
    trace_valid = 1'b1;
    trigger     = 1'b1;
    trace       = 8'hEE;
    step();
    arm         = 1'b0;
    trace_valid = 1'b0;
    trigger     = 1'b0;
    control     = '1;
  endtask

  task automatic smp(input logic [7:0] v, input logic trg);
    trace_valid = 1'b1;
    trace       = v;
    trigger     = trg;
    step();
    trace_valid = 1'b0;
    trigger     = 1'b0;
  endtask

  task automatic gap();
    trace_valid = 1'b0;
    trace       = 8'hA5;
    trigger     = 1'b1;
    step();
    trigger     = 1'b0;
  endtask

  // One 8-bit-mode word with index w; bytes are w*4+k+1, written to address w mod 32.
  task automatic word8(input int w, input int trig_k, input bit gaps, input bit push);
    logic [31:0] d;
    logic [7:0]  b[4];
    for (int k = 0; k < 4; k++) begin
      b[k] = 8'(w * 4 + k + 1);
      d[k*8 +: 8] = b[k];
    end
    if (push) exp_q.push_back('{addr: TRB_WADDR_BITS'(w), data: d});
    for (int k = 0; k < 4; k++) begin
      smp(b[k], k == trig_k);
      if (gaps) gap();
    end
  endtask

  task automatic drain(input string name);
    step();
    step();
    chk({name, ".pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    arm         = 1'b0;
    control     = '0;
    trace       = '0;
    trace_valid = 1'b0;
    trigger     = 1'b0;
    #23;
    chk("rst.we", 32'(we), 32'd0);
    chk("rst.waddr", 32'(waddr), 32'd0);
    chk("rst.wdata", wdata, 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk_status("rst", 1'b0, 0, 0);
    rst_n = 1'b1;
    step();

    // Byte packing, trigger on third sample, no post window
    do_arm(mk_ctrl(1'b0, 0, 3));
    chk("t1.busy_armed", 32'(busy), 32'd1);
    chk_status("t1.armed", 1'b0, 0, 0);
    smp(8'h11, 1'b0);
    smp(8'h22, 1'b0);
    smp(8'h33, 1'b1);
    chk_status("t1", 1'b1, 16, 0);
    exp_q.push_back('{addr: 5'd0, data: 32'h44332211});
    smp(8'h44, 1'b0);
    chk("t1.we", 32'(we), 32'd1);
    step();
    chk("t1.done", 32'(done), 32'd1);
    chk("t1.busy", 32'(busy), 32'd0);
    for (int i = 0; i < 6; i++) smp(8'h99, 1'b1);
    chk_status("t1.frozen", 1'b1, 16, 0);
    drain("t1");

    // 1-bit packing, upper trace bits ignored, trigger on last sample
    do_arm(mk_ctrl(1'b0, 0, 0));
    exp_q.push_back('{addr: 5'd0, data: 32'h55555555});
    for (int i = 0; i < 32; i++) smp((i % 2 == 0) ? 8'hFF : 8'hFE, i == 31);
    chk_status("t2", 1'b1, 31, 0);
    step();
    chk("t2.done", 32'(done), 32'd1);
    drain("t2");

    // Delay 3: trigger in word 5, 24 post words, last at address 29
    do_arm(mk_ctrl(1'b0, 3, 3));
    for (int w = 0; w < 30; w++) word8(w, (w == 5) ? 0 : -1, 1'b0, 1'b1);
    chk("t3.last_waddr", 32'(waddr), 32'd29);
    chk("t3.done_at_write", 32'(done), 32'd0);
    chk("t3.busy_at_write", 32'(busy), 32'd1);
    step();
    chk("t3.done", 32'(done), 32'd1);
    chk("t3.busy", 32'(busy), 32'd0);
    chk_status("t3", 1'b1, 0, 5);
    word8(40, -1, 1'b0, 1'b0);
    drain("t3");

    // Wrap with 50% valid gaps: trigger in word 30, post writes 31,0..6
    do_arm(mk_ctrl(1'b0, 1, 3));
    for (int w = 0; w < 39; w++) word8(w, (w == 30) ? 2 : -1, 1'b1, 1'b1);
    step();
    chk("t4.done", 32'(done), 32'd1);
    chk_status("t4", 1'b1, 16, 30);
    drain("t4");

    // Streaming: done after 8 post words, writes keep wrapping, status frozen
    do_arm(mk_ctrl(1'b1, 1, 3));
    for (int w = 0; w < 9; w++) word8(w, (w == 0) ? 0 : -1, 1'b0, 1'b1);
    chk("t5.done_at_write", 32'(done), 32'd0);
    step();
    chk("t5.done", 32'(done), 32'd1);
    for (int w = 9; w < 39; w++) word8(w, 1, 1'b0, 1'b1);
    chk("t5.done_stays", 32'(done), 32'd1);
    chk("t5.busy", 32'(busy), 32'd0);
    chk_status("t5", 1'b1, 0, 0);
    drain("t5");

    // Re-arm mid-POST clears status and restarts at address 0
    do_arm(mk_ctrl(1'b0, 3, 3));
    for (int w = 0; w < 3; w++) word8(w, (w == 0) ? 1 : -1, 1'b0, 1'b1);
    chk("t6.busy_post", 32'(busy), 32'd1);
    chk_status("t6.post", 1'b1, 8, 0);
    smp(8'h77, 1'b0);
    smp(8'h66, 1'b0);
    do_arm(mk_ctrl(1'b0, 0, 3));
    chk_status("t6.rearm", 1'b0, 0, 0);
    chk("t6.done", 32'(done), 32'd0);
    chk("t6.busy", 32'(busy), 32'd1);
    word8(0, -1, 1'b0, 1'b1);
    drain("t6");

    // Asynchronous reset while a write is being presented
    word8(1, -1, 1'b0, 1'b0);
    chk("t7.we_before", 32'(we), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t7.we", 32'(we), 32'd0);
    chk("t7.waddr", 32'(waddr), 32'd0);
    chk("t7.wdata", wdata, 32'd0);
    chk("t7.busy", 32'(busy), 32'd0);
    chk("t7.done", 32'(done), 32'd0);
    chk_status("t7", 1'b0, 0, 0);
    step();
    rst_n = 1'b1;
    drain("t7");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
